// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential PC requests to instruction memory and
// buffers in-order responses for downstream, with redirect flush and discard of stale responses.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr_data,
  output logic [XLEN-1:0] instr_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]     buf_data_q [DEPTH];
  logic [XLEN-1:0] buf_pc_q   [DEPTH];

  logic credit_ok, req_fire, rsp_seen, rsp_drop, push, pop;

  // Handshakes: a transfer happens on any cycle where valid and ready are both high;
  // valid never depends on ready, and ready may change freely while valid is low.
  always_comb begin
    credit_ok      = ({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_W;
    imem_req_valid = credit_ok && !redirect_valid && !reset;
    imem_req_addr  = pc_q;
    instr_valid    = (count_q != '0) && !redirect_valid && !reset;
    instr_data     = buf_data_q[rd_ptr_q];
    instr_pc       = buf_pc_q[rd_ptr_q];

    req_fire = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a memory protocol error; ignoring it keeps counters sane.
    rsp_seen = imem_rsp_valid && (outstanding_q != '0);
    rsp_drop = rsp_seen && (discard_q != '0);
    push     = rsp_seen && (discard_q == '0) && !redirect_valid;
    pop      = instr_valid && instr_ready;

    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    if (redirect_valid) begin
      // Every request still in flight belongs to the old path and must be dropped.
      pc_d          = redirect_pc;
      rsp_pc_d      = redirect_pc;
      count_d       = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      outstanding_d = outstanding_q - CW'(rsp_seen);
      discard_d     = outstanding_q - CW'(rsp_seen);
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(4);
      if (push) begin
        rsp_pc_d = rsp_pc_q + XLEN'(4);
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d       = count_q + CW'(push) - CW'(pop);
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_seen);
      discard_d     = discard_q - CW'(rsp_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data_q[wr_ptr_q] <= imem_rsp_data;
      buf_pc_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirects, PC wrap and mid-stream reset.
module tb_fetch_unit;

  localparam logic [31:0] K = 32'hC0DE_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req_ready = 1'b1, redirect_valid = 1'b0, instr_ready = 1'b1, rsp_en = 1'b1;
  logic [31:0] redirect_pc = '0;

  logic        req_valid, rsp_valid, instr_valid;
  logic [31:0] req_addr, rsp_data, instr_data, instr_pc;
  logic        w_req_valid, w_rsp_valid, w_instr_valid;
  logic [31:0] w_req_addr, w_rsp_data, w_instr_data, w_instr_pc;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] mem_q[$];
  logic [31:0] w_mem_q[$];

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0100), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_w (
    .clk(clk), .reset(reset),
    .imem_req_valid(w_req_valid), .imem_req_ready(req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(w_instr_valid), .instr_ready(instr_ready),
    .instr_data(w_instr_data), .instr_pc(w_instr_pc)
  );

  // In-order memory, one cycle latency; data word is the request address xor K.
  always @(posedge clk) begin
    if (reset) begin
      mem_q.delete();
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if (req_valid && req_ready) mem_q.push_back(req_addr);
      if (rsp_en && mem_q.size() != 0) begin
        rsp_valid <= 1'b1;
        rsp_data  <= mem_q.pop_front() ^ K;
      end else begin
        rsp_valid <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      w_mem_q.delete();
      w_rsp_valid <= 1'b0;
      w_rsp_data  <= '0;
    end else begin
      if (w_req_valid && req_ready) w_mem_q.push_back(w_req_addr);
      if (rsp_en && w_mem_q.size() != 0) begin
        w_rsp_valid <= 1'b1;
        w_rsp_data  <= w_mem_q.pop_front() ^ K;
      end else begin
        w_rsp_valid <= 1'b0;
      end
    end
  end

  // Leaves the caller just after the falling edge that starts cycle c0, reset released.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    req_ready = 1'b1; instr_ready = 1'b1; rsp_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    tests_run++; if (req_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_req_valid got %b exp 0", req_valid); end
    tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_instr_valid got %b exp 0", instr_valid); end
    @(negedge clk);
    reset = 1'b0; #1;
    tests_run++; if (req_valid !== 1'b1 || req_addr !== 32'h0000_0100) begin tests_failed++; $display("FAIL reset_first_req got v=%b a=%h exp v=1 a=00000100", req_valid, req_addr); end
    tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_empty got %b exp 0", instr_valid); end
    tests_run++; if (w_req_addr !== 32'hFFFF_FFF8) begin tests_failed++; $display("FAIL reset_pc_param got %h exp fffffff8", w_req_addr); end
  endtask

  task automatic test_streaming();
    logic [31:0] exp_pc;
    do_reset();
    @(negedge clk); #1;
    tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_no_bypass got %b exp 0", instr_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      exp_pc = 32'h100 + 32'(4 * i);
      tests_run++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_data !== (exp_pc ^ K)) begin
        tests_failed++;
        $display("FAIL stream_%0d got v=%b pc=%h d=%h exp v=1 pc=%h d=%h", i, instr_valid, instr_pc, instr_data, exp_pc, exp_pc ^ K);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    do_reset();
    instr_ready = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (req_valid !== 1'b0 || dut.count_q !== 3'd4 || instr_pc !== 32'h100) begin
        tests_failed++;
        $display("FAIL bp_full_%0d got rv=%b cnt=%0d pc=%h exp rv=0 cnt=4 pc=00000100", i, req_valid, dut.count_q, instr_pc);
      end
      @(negedge clk);
    end
    instr_ready = 1'b1; #1;
    tests_run++; if (instr_pc !== 32'h100 || req_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drain0 got pc=%h rv=%b exp pc=00000100 rv=0", instr_pc, req_valid); end
    @(negedge clk); #1;
    tests_run++; if (instr_pc !== 32'h104 || req_valid !== 1'b1 || req_addr !== 32'h110) begin tests_failed++; $display("FAIL bp_resume got pc=%h rv=%b a=%h exp pc=00000104 rv=1 a=00000110", instr_pc, req_valid, req_addr); end
    for (int i = 2; i < 5; i++) begin
      @(negedge clk); #1;
      exp_pc = 32'h100 + 32'(4 * i);
      tests_run++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_data !== (exp_pc ^ K)) begin
        tests_failed++;
        $display("FAIL bp_drain%0d got v=%b pc=%h d=%h exp pc=%h", i, instr_valid, instr_pc, instr_data, exp_pc);
      end
    end
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    rsp_en = 1'b0;
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h2000; #1;
    tests_run++; if (req_valid !== 1'b0 || instr_valid !== 1'b0 || dut.outstanding_q !== 3'd3) begin tests_failed++; $display("FAIL rdi_cycle got rv=%b iv=%b out=%0d exp rv=0 iv=0 out=3", req_valid, instr_valid, dut.outstanding_q); end
    @(negedge clk);
    redirect_valid = 1'b0; rsp_en = 1'b1; #1;
    tests_run++; if (req_valid !== 1'b1 || req_addr !== 32'h2000) begin tests_failed++; $display("FAIL rdi_fetch got rv=%b a=%h exp rv=1 a=00002000", req_valid, req_addr); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL rdi_drop%0d got iv=%b pc=%h exp iv=0", i, instr_valid, instr_pc); end
    end
    @(negedge clk); #1;
    tests_run++; if (instr_valid !== 1'b1 || instr_pc !== 32'h2000 || instr_data !== (32'h2000 ^ K)) begin tests_failed++; $display("FAIL rdi_first got v=%b pc=%h d=%h exp v=1 pc=00002000 d=%h", instr_valid, instr_pc, instr_data, 32'h2000 ^ K); end
  endtask

  task automatic test_redirect_rsp();
    do_reset();
    rsp_en = 1'b0;
    @(negedge clk);
    rsp_en = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h3000;
    @(negedge clk);
    redirect_valid = 1'b0; #1;
    tests_run++; if (dut.discard_q !== 3'd1) begin tests_failed++; $display("FAIL rdr_discard got %0d exp 1", dut.discard_q); end
    tests_run++; if (req_valid !== 1'b1 || req_addr !== 32'h3000 || instr_valid !== 1'b0) begin tests_failed++; $display("FAIL rdr_fetch got rv=%b a=%h iv=%b exp rv=1 a=00003000 iv=0", req_valid, req_addr, instr_valid); end
    @(negedge clk); #1;
    tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL rdr_gap got iv=%b pc=%h exp iv=0", instr_valid, instr_pc); end
    @(negedge clk); #1;
    tests_run++; if (instr_valid !== 1'b1 || instr_pc !== 32'h3000 || instr_data !== (32'h3000 ^ K)) begin tests_failed++; $display("FAIL rdr_first got v=%b pc=%h d=%h exp v=1 pc=00003000 d=%h", instr_valid, instr_pc, instr_data, 32'h3000 ^ K); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h4000;
    @(negedge clk);
    redirect_pc = 32'h5000;
    @(negedge clk);
    redirect_valid = 1'b0; #1;
    tests_run++; if (req_valid !== 1'b1 || req_addr !== 32'h5000) begin tests_failed++; $display("FAIL b2b_fetch got rv=%b a=%h exp rv=1 a=00005000", req_valid, req_addr); end
    @(negedge clk); #1;
    tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_gap got iv=%b pc=%h exp iv=0", instr_valid, instr_pc); end
    @(negedge clk); #1;
    tests_run++; if (instr_valid !== 1'b1 || instr_pc !== 32'h5000 || instr_data !== (32'h5000 ^ K)) begin tests_failed++; $display("FAIL b2b_first got v=%b pc=%h d=%h exp v=1 pc=00005000", instr_valid, instr_pc, instr_data); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      exp_pc = 32'hFFFF_FFF8 + 32'(4 * i);
      tests_run++;
      if (w_instr_valid !== 1'b1 || w_instr_pc !== exp_pc || w_instr_data !== (exp_pc ^ K)) begin
        tests_failed++;
        $display("FAIL wrap_%0d got v=%b pc=%h d=%h exp v=1 pc=%h", i, w_instr_valid, w_instr_pc, w_instr_data, exp_pc);
      end
    end
  endtask

  task automatic test_midreset();
    do_reset();
    instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    rsp_en = 1'b0;
    repeat (2) @(negedge clk); #1;
    tests_run++; if (dut.count_q !== 3'd2 || dut.outstanding_q !== 3'd2) begin tests_failed++; $display("FAIL mr_setup got cnt=%0d out=%0d exp cnt=2 out=2", dut.count_q, dut.outstanding_q); end
    reset = 1'b1; #1;
    tests_run++; if (req_valid !== 1'b0 || instr_valid !== 1'b0) begin tests_failed++; $display("FAIL mr_during got rv=%b iv=%b exp 0 0", req_valid, instr_valid); end
    @(negedge clk);
    reset = 1'b0; rsp_en = 1'b1; instr_ready = 1'b1; #1;
    tests_run++; if (instr_valid !== 1'b0 || req_addr !== 32'h100 || req_valid !== 1'b1) begin tests_failed++; $display("FAIL mr_after got iv=%b a=%h rv=%b exp iv=0 a=00000100 rv=1", instr_valid, req_addr, req_valid); end
    @(negedge clk); #1;
    tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL mr_flushed got iv=%b pc=%h exp iv=0", instr_valid, instr_pc); end
    @(negedge clk); #1;
    tests_run++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr_data !== (32'h100 ^ K)) begin tests_failed++; $display("FAIL mr_first got v=%b pc=%h d=%h exp v=1 pc=00000100", instr_valid, instr_pc, instr_data); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_rsp();
    test_back_to_back();
    test_wrap();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d tests", tests_run);
    $fatal(1, "watchdog");
  end

endmodule
